// File: rtl/gpio_bus_arb.sv
// Round-robin arbiter sharing one GPIO device port between NumHosts bus hosts.
// An in-order ID FIFO routes each device response back to the host that issued it.
module gpio_bus_arb #(
   parameter  int unsigned NumHosts       = 2,
   parameter  int unsigned MaxOutstanding = 2,
   localparam int unsigned IdxW           = $clog2(NumHosts)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NumHosts-1:0]      host_req_i,
   output logic [NumHosts-1:0]      host_gnt_o,
   input  logic [NumHosts*32-1:0]   host_addr_i,
   input  logic [NumHosts-1:0]      host_we_i,
   input  logic [NumHosts*4-1:0]    host_be_i,
   input  logic [NumHosts*32-1:0]   host_wdata_i,
   output logic [NumHosts-1:0]      host_rvalid_o,
   output logic [31:0]              host_rdata_o,
   output logic                     device_req_o,
   output logic [31:0]              device_addr_o,
   output logic                     device_we_o,
   output logic [3:0]               device_be_o,
   output logic [31:0]              device_wdata_o,
   input  logic                     device_rvalid_i,
   input  logic [31:0]              device_rdata_i,
   output logic [2:0]               outstanding_o,
   output logic                     resp_err_o
);

   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   logic [IdxW-1:0] rr_q;
   logic [IdxW-1:0] gnt_idx;
   logic            gnt_valid;
   logic            can_issue;
   logic            empty;
   logic            push;
   logic            pop;
   logic [IdxW-1:0] head_id;
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [2:0]      count_q;
   logic [IdxW-1:0] id_mem_q [MaxOutstanding];

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty = (count_q == 3'd0);
   // Grants are qualified by rst_ni so every output reads zero while reset is held.
   assign can_issue = rst_ni & ((count_q < 3'(MaxOutstanding)) | device_rvalid_i);

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin : arbitrate
      int unsigned cand;
      cand      = 0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int unsigned i = 0; i < NumHosts; i++) begin
         cand = (32'(rr_q) + i) % NumHosts;
         if (can_issue && !gnt_valid && host_req_i[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = IdxW'(cand);
         end
      end
   end

   assign host_gnt_o     = gnt_valid ? (NumHosts'(1) << gnt_idx) : '0;
   assign device_req_o   = gnt_valid;
   assign device_addr_o  = gnt_valid ? host_addr_i[32*gnt_idx +: 32]  : '0;
   assign device_we_o    = gnt_valid ? host_we_i[gnt_idx]              : 1'b0;
   assign device_be_o    = gnt_valid ? host_be_i[4*gnt_idx +: 4]       : '0;
   assign device_wdata_o = gnt_valid ? host_wdata_i[32*gnt_idx +: 32] : '0;

   assign push    = gnt_valid;
   assign pop     = device_rvalid_i & ~empty;
   assign head_id = id_mem_q[rd_ptr_q];

   assign host_rvalid_o = pop ? (NumHosts'(1) << head_id) : '0;
   assign host_rdata_o  = device_rdata_i;
   assign resp_err_o    = rst_ni & device_rvalid_i & empty;
   assign outstanding_o = count_q;

   // NOTE: state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            rr_q     <= (gnt_idx == IdxW'(NumHosts - 1)) ? '0 : gnt_idx + 1'b1;
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 3'd1;
            2'b01:   count_q <= count_q - 3'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the ID storage has no reset; entries are only read once count_q marks them valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         id_mem_q[wr_ptr_q] <= gnt_idx;
      end
   end

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Directed and randomized bench for gpio_bus_arb, checked every cycle against
// a queue-based model of the arbitration and response-routing rules.
module tb_gpio_bus_arb;

   localparam int N    = 2;
   localparam int MAXO = 2;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic [N-1:0]    host_req_i = '0;
   logic [N-1:0]    host_gnt_o;
   logic [N*32-1:0] host_addr_i = '0;
   logic [N-1:0]    host_we_i = '0;
   logic [N*4-1:0]  host_be_i = '0;
   logic [N*32-1:0] host_wdata_i = '0;
   logic [N-1:0]    host_rvalid_o;
   logic [31:0]     host_rdata_o;
   logic            device_req_o;
   logic [31:0]     device_addr_o;
   logic            device_we_o;
   logic [3:0]      device_be_o;
   logic [31:0]     device_wdata_o;
   logic            device_rvalid_i = 1'b0;
   logic [31:0]     device_rdata_i = '0;
   logic [2:0]      outstanding_o;
   logic            resp_err_o;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: in-order host IDs awaiting a response, and the round-robin start.
   int           q[$];
   int           rr = 0;
   logic [N-1:0] last_gnt = '0;

   gpio_bus_arb #(.NumHosts(N), .MaxOutstanding(MAXO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
      .host_addr_i(host_addr_i), .host_we_i(host_we_i),
      .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
      .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
      .device_req_o(device_req_o), .device_addr_o(device_addr_o),
      .device_we_o(device_we_o), .device_be_o(device_be_o),
      .device_wdata_o(device_wdata_o),
      .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
      .outstanding_o(outstanding_o), .resp_err_o(resp_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_host(input int h, input bit req, input bit we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
      host_req_i[h]           = req;
      host_we_i[h]            = we;
      host_addr_i[32*h +: 32] = addr;
      host_be_i[4*h +: 4]     = be;
      host_wdata_i[32*h +: 32] = wd;
   endtask

   task automatic idle();
      host_req_i = '0; host_we_i = '0; host_addr_i = '0; host_be_i = '0; host_wdata_i = '0;
      device_rvalid_i = 1'b0; device_rdata_i = '0;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      @(negedge clk_i);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
   endtask

   // Per-cycle model compare, sampled on the falling edge while inputs are stable.
   always @(negedge clk_i) begin
      logic [N-1:0] e_gnt, e_rv;
      logic         e_err;
      logic [31:0]  e_addr, e_wd;
      logic [3:0]   e_be;
      logic         e_we;
      int           best, bestd, d;
      e_gnt = '0; e_rv = '0; e_err = 1'b0; e_addr = '0; e_wd = '0; e_be = '0; e_we = 1'b0;
      best = -1;
      if (!rst_ni) begin
         q.delete();
         rr = 0;
      end else begin
         e_err = device_rvalid_i && (q.size() == 0);
         if (device_rvalid_i && q.size() > 0) e_rv[q[0]] = 1'b1;
         bestd = N;
         for (int k = 0; k < N; k++) begin
            d = (k - rr + N) % N;
            if (host_req_i[k] && d < bestd) begin
               best  = k;
               bestd = d;
            end
         end
         if (!(q.size() < MAXO || device_rvalid_i)) best = -1;
         if (best >= 0) begin
            e_gnt[best] = 1'b1;
            e_addr = host_addr_i[32*best +: 32];
            e_wd   = host_wdata_i[32*best +: 32];
            e_be   = host_be_i[4*best +: 4];
            e_we   = host_we_i[best];
         end
      end
      check("m_gnt", 32'(host_gnt_o), 32'(e_gnt));
      check("m_req", 32'(device_req_o), 32'(best >= 0));
      check("m_addr", device_addr_o, e_addr);
      check("m_we", 32'(device_we_o), 32'(e_we));
      check("m_be", 32'(device_be_o), 32'(e_be));
      check("m_wdata", device_wdata_o, e_wd);
      check("m_rvalid", 32'(host_rvalid_o), 32'(e_rv));
      if (e_rv != '0) check("m_rdata", host_rdata_o, device_rdata_i);
      check("m_outst", 32'(outstanding_o), 32'(q.size()));
      check("m_err", 32'(resp_err_o), 32'(e_err));
      if (rst_ni) begin
         if (device_rvalid_i && q.size() > 0) void'(q.pop_front());
         if (best >= 0) begin
            q.push_back(best);
            rr = (best + 1) % N;
         end
      end
      last_gnt = e_gnt;
   end

   initial begin
      logic [N-1:0] exp_g [5];
      logic [N-1:0] exp_r [5];
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // Single host read.
      set_host(0, 1, 0, 32'h4, 4'hF, 32'h0);
      @(negedge clk_i);
      check("rd_gnt", 32'(host_gnt_o), 32'h1);
      check("rd_addr", device_addr_o, 32'h4);
      check("rd_we", 32'(device_we_o), 32'h0);
      step();
      idle();
      device_rvalid_i = 1'b1; device_rdata_i = 32'hA5;
      @(negedge clk_i);
      check("rd_rvalid", 32'(host_rvalid_o), 32'h1);
      check("rd_rdata", host_rdata_o, 32'hA5);
      step();
      idle();

      // Contention from reset: alternating grants, responses one cycle behind.
      do_reset();
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10; exp_g[4] = 2'b00;
      exp_r[0] = 2'b00; exp_r[1] = 2'b01; exp_r[2] = 2'b10; exp_r[3] = 2'b01; exp_r[4] = 2'b10;
      set_host(0, 1, 0, 32'h10, 4'hF, 32'h0);
      set_host(1, 1, 0, 32'h20, 4'hF, 32'h0);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin
            device_rvalid_i = 1'b1; device_rdata_i = 32'(c);
         end
         if (c == 4) host_req_i = '0;
         @(negedge clk_i);
         check($sformatf("ct_gnt%0d", c), 32'(host_gnt_o), 32'(exp_g[c]));
         check($sformatf("ct_rv%0d", c), 32'(host_rvalid_o), 32'(exp_r[c]));
         step();
      end
      idle();

      // Backpressure with the FIFO full, then a pop freeing a slot in the same cycle.
      set_host(0, 1, 0, 32'h30, 4'hF, 32'h0);
      set_host(1, 1, 0, 32'h40, 4'hF, 32'h0);
      @(negedge clk_i);
      check("bp_gnt0", 32'(host_gnt_o), 32'h1);
      step();
      host_req_i[0] = 1'b0;
      @(negedge clk_i);
      check("bp_gnt1", 32'(host_gnt_o), 32'h2);
      step();
      @(negedge clk_i);
      check("bp_full_gnt", 32'(host_gnt_o), 32'h0);
      check("bp_full_req", 32'(device_req_o), 32'h0);
      check("bp_full_out", 32'(outstanding_o), 32'h2);
      step();
      device_rvalid_i = 1'b1; device_rdata_i = 32'h55;
      @(negedge clk_i);
      check("bp_pop_gnt", 32'(host_gnt_o), 32'h2);
      check("bp_pop_rv", 32'(host_rvalid_o), 32'h1);
      check("bp_pop_out", 32'(outstanding_o), 32'h2);
      step();
      host_req_i = '0;
      @(negedge clk_i);
      check("bp_out_hold", 32'(outstanding_o), 32'h2);
      repeat (2) step();
      idle();
      @(negedge clk_i);
      check("bp_drained", 32'(outstanding_o), 32'h0);
      step();

      // Write forwarding and its acknowledgement.
      set_host(1, 1, 1, 32'h0, 4'b0011, 32'h1234);
      @(negedge clk_i);
      check("wr_gnt", 32'(host_gnt_o), 32'h2);
      check("wr_we", 32'(device_we_o), 32'h1);
      check("wr_be", 32'(device_be_o), 32'h3);
      check("wr_wdata", device_wdata_o, 32'h1234);
      step();
      idle();
      device_rvalid_i = 1'b1;
      @(negedge clk_i);
      check("wr_ack", 32'(host_rvalid_o), 32'h2);
      step();

      // Spurious response with nothing outstanding.
      @(negedge clk_i);
      check("sp_err", 32'(resp_err_o), 32'h1);
      check("sp_rv", 32'(host_rvalid_o), 32'h0);
      check("sp_out", 32'(outstanding_o), 32'h0);
      step();
      idle();
      @(negedge clk_i);
      check("sp_err_gone", 32'(resp_err_o), 32'h0);
      step();

      // Reset while a transaction is outstanding.
      set_host(0, 1, 0, 32'h8, 4'hF, 32'h0);
      step();
      host_req_i = '0;
      @(negedge clk_i);
      check("rs_out_pre", 32'(outstanding_o), 32'h1);
      #2;
      host_req_i = 2'b11;
      rst_ni = 1'b0;
      #1;
      check("rs_gnt", 32'(host_gnt_o), 32'h0);
      check("rs_req", 32'(device_req_o), 32'h0);
      check("rs_out", 32'(outstanding_o), 32'h0);
      check("rs_rv", 32'(host_rvalid_o), 32'h0);
      @(negedge clk_i);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(negedge clk_i);
      check("rs_first_gnt", 32'(host_gnt_o), 32'h1);
      step();
      idle();
      step();

      // Randomized traffic: hosts hold their request until the model grants it.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int h = 0; h < N; h++) begin
            if (!host_req_i[h] || last_gnt[h]) begin
               set_host(h, $urandom_range(0, 99) < 60, $urandom_range(0, 1), $urandom,
                        4'($urandom), $urandom);
            end
         end
         device_rvalid_i = $urandom_range(0, 99) < 50;
         device_rdata_i  = $urandom;
         step();
      end
      idle();
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gpio_bus_arb.md
Name: gpio_bus_arb

Overview:
Round-robin arbiter that shares the single GPIO device bus port between NumHosts bus hosts, e.g. the Ibex data port and a debug/DMA master. It sits between the bus hosts and the GPIO peripheral. Host requests are forwarded to the device one per cycle. A small in-order ID FIFO of outstanding transactions routes each device response back to the host that issued it.

Parameters:
NumHosts, 2, number of host ports (legal 2..4).
MaxOutstanding, 2, depth of the outstanding-ID FIFO (legal 1..4).
IdxW, $clog2(NumHosts), derived, width of host index; not overridable.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
host_req_i  input  NumHosts  per-host request
host_gnt_o  output  NumHosts  per-host grant, one-hot or zero
host_addr_i  input  NumHosts*32  per-host address, host i at [32*i+:32]
host_we_i  input  NumHosts  per-host write enable
host_be_i  input  NumHosts*4  per-host byte enables
host_wdata_i  input  NumHosts*32  per-host write data
host_rvalid_o  output  NumHosts  per-host response valid
host_rdata_o  output  32  shared response data, qualified by host_rvalid_o
device_req_o  output  1  request to GPIO
device_addr_o  output  32  forwarded address
device_we_o  output  1  forwarded write enable
device_be_o  output  4  forwarded byte enables
device_wdata_o  output  32  forwarded write data
device_rvalid_i  input  1  GPIO response valid
device_rdata_i  input  32  GPIO response data
outstanding_o  output  3  number of issued, unanswered transactions
resp_err_o  output  1  one-cycle pulse on an unexpected response

Behaviour:
- Clock, reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset state:
  - rr_q = 0, FIFO empty, count = 0.
  - host_gnt_o = 0, host_rvalid_o = 0, device_req_o = 0, outstanding_o = 0, resp_err_o = 0.
- Acceptance:
  - can_issue = (count < MaxOutstanding) | device_rvalid_i. A pop in the same cycle frees a slot when the FIFO is full.
  - If no slot is free, all grants are 0 and device_req_o = 0, even with requests pending.
- Arbitration (combinational, same cycle):
  - Search host indices starting at rr_q, wrapping modulo NumHosts.
  - The first requesting host k gets host_gnt_o[k] = 1, provided can_issue.
  - At most one grant per cycle.
  - Zero-latency grant: a request is granted in the same cycle it is first presented.
- Forwarding:
  - device_req_o = |host_gnt_o.
  - device_addr_o, device_we_o, device_be_o and device_wdata_o are muxed from the granted host.
  - With no grant these outputs are 0.
- Hosts: each host holds req, addr, we, be and wdata stable until granted. The arbiter does not register requests.
- Pointer update: on a grant to host k, rr_q <= (k+1) mod NumHosts. Without a grant, rr_q is unchanged.
- ID FIFO:
  - On a grant, push k.
  - On device_rvalid_i with the FIFO non-empty, pop the head.
  - Push and pop in the same cycle: count unchanged; legal even when full.
  - Pointers wrap modulo MaxOutstanding.
  - outstanding_o = count, zero-extended.
- Response routing:
  - host_rvalid_o[head] = device_rvalid_i & ~empty; all other bits 0.
  - host_rdata_o = device_rdata_i, passed through combinationally.
- Write responses: a write is still returned as a response; the GPIO acks every request, writes included.
- Unexpected response: device_rvalid_i with the FIFO empty → no host_rvalid_o; resp_err_o = 1 for that cycle (registered-free, combinational). FIFO state is unchanged.
- Latency: the arbiter adds zero cycles in both directions. With the GPIO (rvalid one cycle after req), a host sees rvalid one cycle after its grant.
- Throughput: with MaxOutstanding ≥ 1 and a one-cycle device, one grant per cycle is sustained.
- Reset mid-transaction: FIFO and pointer clear immediately. A response arriving after reset release for a pre-reset request is treated as unexpected.

Test Plan:
- Single host: host0 reads addr 0x4 → gnt0 in the same cycle; device_addr_o = 0x4, device_we_o = 0; next cycle device_rvalid_i with rdata 0xA5 → host_rvalid_o = 2'b01, host_rdata_o = 0xA5.
- Contention: both hosts hold req for 4 cycles from reset, device acks each after 1 cycle → grants 0, 1, 0, 1; rvalids routed 0, 1, 0, 1 one cycle after each grant.
- Backpressure: MaxOutstanding = 2, device withholds rvalid → two grants issued, then gnt = 0 and device_req_o = 0 with outstanding_o = 2. One rvalid arrives with host1 requesting → host1 is granted in that same cycle and outstanding_o stays 2.
- Write forwarding: host1 writes addr 0x0, be = 4'b0011, wdata = 0x1234 → device_be_o = 0x3, device_wdata_o = 0x1234, device_we_o = 1; the ack rvalid goes only to host1.
- Spurious response: device_rvalid_i with the FIFO empty → resp_err_o pulses for 1 cycle, host_rvalid_o = 0, outstanding_o stays 0.
- Reset mid-operation: assert rst_ni low with outstanding_o = 1 → all outputs 0 asynchronously. After release, both hosts request → host0 is granted first.
